uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_SIZE, default 8: number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16: oversampling ticks spent in the stop bit (16 = 1 stop bit).
REQ-003 Parameter BAUD_DIV, default 163: i_clk cycles per 16x oversampling tick (50 MHz / (19200*16), rounded).
REQ-004 i_clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 i_reset  input  1  synchronous, active-low reset; sampled on the i_clk rising edge.
REQ-006 i_rx  input  1  asynchronous serial line, idles high.
REQ-007 o_rx_done  output  1  one-cycle pulse: a valid frame was received and o_data was updated.
REQ-008 o_data  output  DATA_SIZE  last valid received byte; held stable between o_rx_done pulses.
REQ-009 o_frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-010 i_rx SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value only.
REQ-011 Tick generator SHALL pulse tick for one cycle every BAUD_DIV i_clk cycles, free-running, counter wraps from BAUD_DIV-1 to 0.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; tick counter s (4 bits), bit counter n (log2 DATA_SIZE bits), shift register b (DATA_SIZE bits).
REQ-013 IDLE: on synchronized rx low, clear s, go to START; o_rx_done and o_frame_err stay 0.
REQ-014 START: on each tick increment s; when s reaches 7 (mid start bit) resample rx: low -> clear s and n, go to DATA; high -> return to IDLE (glitch rejection, no output activity).
REQ-015 DATA: on each tick increment s; when s wraps 15 -> 0, shift rx into b MSB (LSB-first line order); after bit n = DATA_SIZE-1, go to STOP with s cleared.
REQ-016 STOP: on each tick increment s; when s reaches SB_TICK-1: rx high -> load o_data from b and pulse o_rx_done; rx low -> pulse o_frame_err, o_data unchanged; both cases return to IDLE.
REQ-017 o_rx_done / o_frame_err SHALL assert in the i_clk cycle after the final stop tick and last exactly one cycle; they SHALL never assert together.
REQ-018 A new start edge SHALL be accepted from IDLE the cycle after return, so back-to-back frames with no idle gap are received.
REQ-019 Line held low continuously (break): frame ends with o_frame_err; FSM then re-enters START on the still-low line and repeats, never asserting o_rx_done.
REQ-020 Ticks are only counted in START/DATA/STOP; cycles without tick leave s, n, b unchanged.

Reset
REQ-021 While i_reset = 0 at a clock edge: FSM -> IDLE, s, n, b, tick counter -> 0, synchronizer flops -> 1, o_data -> 0, o_rx_done -> 0, o_frame_err -> 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no done/error pulse; reception resumes on the next start edge after release.

Structure
REQ-023 Shared package SHALL hold the FSM state encoding constants (IDLE, START, DATA, STOP) and the default DATA_SIZE, SB_TICK, BAUD_DIV values, reused by the UART transmitter.
REQ-024 Tick generator SHALL be a separate sub-module baud_gen (parameter BAUD_DIV, ports i_clk, i_reset, o_tick), shared with the transmitter.
REQ-025 o_rx_done and o_data SHALL connect directly to the downstream interface block's rx-done and rx-data inputs.

Verification (BAUD_DIV = 4 for speed; 64 cycles per bit)
REQ-026 Frame 0xA5, 1 stop bit -> exactly one o_rx_done pulse, o_data = 0xA5, o_frame_err never high.
REQ-027 Back-to-back frames 0x03, 0x05, 0x20 with zero idle gap -> three o_rx_done pulses, o_data sequence 0x03, 0x05, 0x20.
REQ-028 Low glitch on i_rx lasting 3 ticks, then high -> no o_rx_done, no o_frame_err, FSM back in IDLE; following frame 0x7E received correctly.
REQ-029 Frame 0x3C with stop bit driven low -> one o_frame_err pulse, no o_rx_done, o_data keeps previous value.
REQ-030 i_reset = 0 for 2 cycles during data bit 4 of 0xFF -> all outputs 0, no pulses; next frame 0x00 -> o_rx_done, o_data = 0x00.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding and default frame/baud parameters,
// common to the receiver and transmitter.
package uart_rx_pkg;

    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_SB_TICK   = 16;
    localparam int DEF_BAUD_DIV  = 163;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } uart_state_e;

    // Counter width able to index 0..range-1, never narrower than one bit.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART signal bundle: serial line in, received byte and status pulses out.
interface uart_rx_if #(
    parameter int DATA_SIZE = uart_rx_pkg::DEF_DATA_SIZE
);

    logic                 i_rx;
    logic                 o_rx_done;
    logic [DATA_SIZE-1:0] o_data;
    logic                 o_frame_err;

    modport master (
        input  i_rx,
        output o_rx_done,
        output o_data,
        output o_frame_err
    );

    modport slave (
        output i_rx,
        input  o_rx_done,
        input  o_data,
        input  o_frame_err
    );

endinterface

// File: rtl/uart_rx_baud_gen.sv
// Free-running oversampling tick generator: one-cycle tick every BAUD_DIV clocks.
module baud_gen
    import uart_rx_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    localparam int             CW       = cnt_width(BAUD_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter; the tick is registered on the wrap cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CNT_ONE;
            tick_r <= 1'b0;
        end
    end

    assign o_tick = tick_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first frames with start-bit glitch rejection
// and stop-bit framing check; status outputs are single-cycle registered pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int SB_TICK   = DEF_SB_TICK,
    parameter int BAUD_DIV  = DEF_BAUD_DIV
) (
    input  logic       i_clk,
    input  logic       i_reset,
    uart_rx_if.master  bus
);

    localparam int            NW     = cnt_width(DATA_SIZE);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_SIZE - 1);
    localparam logic [NW-1:0] N_ONE  = NW'(1);
    localparam logic [3:0]    S_MID  = 4'd7;
    localparam logic [3:0]    S_LAST = 4'd15;
    localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);

    logic                 sync1_r;
    logic                 sync2_r;
    logic                 rx_s;
    logic                 tick_s;

    uart_state_e          state_r;
    logic [3:0]           s_r;
    logic [NW-1:0]        n_r;
    logic [DATA_SIZE-1:0] b_r;
    logic [DATA_SIZE-1:0] data_r;
    logic                 done_r;
    logic                 ferr_r;

    baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_tick  (tick_s)
    );

    // Two-flop synchronizer for the asynchronous line; resets to the idle level.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= bus.i_rx;
            sync2_r <= sync1_r;
        end
    end

    assign rx_s = sync2_r;

    // Frame FSM with its counters, shift register and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_r <= IDLE;
            s_r     <= 4'd0;
            n_r     <= '0;
            b_r     <= '0;
            data_r  <= '0;
            done_r  <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            ferr_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        s_r     <= 4'd0;
                        state_r <= START;
                    end
                end
                START: begin
                    if (tick_s) begin
                        // Mid start bit: a line that is high again was only a glitch.
                        if (s_r == S_MID) begin
                            if (!rx_s) begin
                                s_r     <= 4'd0;
                                n_r     <= '0;
                                state_r <= DATA;
                            end else begin
                                state_r <= IDLE;
                            end
                        end else begin
                            s_r <= s_r + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        if (s_r == S_LAST) begin
                            s_r <= 4'd0;
                            b_r <= {rx_s, b_r[DATA_SIZE-1:1]};
                            if (n_r == N_LAST) begin
                                state_r <= STOP;
                            end else begin
                                n_r <= n_r + N_ONE;
                            end
                        end else begin
                            s_r <= s_r + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        if (s_r == S_STOP) begin
                            if (rx_s) begin
                                data_r <= b_r;
                                done_r <= 1'b1;
                            end else begin
                                ferr_r <= 1'b1;
                            end
                            state_r <= IDLE;
                        end else begin
                            s_r <= s_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_rx_done   = done_r;
    assign bus.o_data      = data_r;
    assign bus.o_frame_err = ferr_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed serial frames, an event-queue model of
// expected done/error pulses and held data, checked on every falling clock edge.
module tb_uart_rx;

    localparam int DS  = 8;
    localparam int BD  = 4;
    localparam int BIT = 16 * BD;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         lo;
        int         hi;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    logic       rst_low_at_edge = 1'b0;
    logic [7:0] exp_data = 8'h00;
    ev_t        exp_q[$];
    int         tests = 0;
    int         fails = 0;

    uart_rx_if #(.DATA_SIZE(DS)) bus();

    uart_rx #(
        .DATA_SIZE (DS),
        .SB_TICK   (16),
        .BAUD_DIV  (BD)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc             <= cyc + 1;
        rst_low_at_edge <= !rst_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input bit is_err, input logic [7:0] d, input int lo, input int hi);
        ev_t e;
        e.is_err = is_err;
        e.data   = d;
        e.lo     = lo;
        e.hi     = hi;
        exp_q.push_back(e);
    endtask

    // One frame starting now; the pulse must land inside the stop-bit period.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int stop_len);
        int t0;
        t0 = cyc;
        push_ev(!stop_bit, d, t0 + 9 * BIT, t0 + 10 * BIT);
        bus.i_rx = 1'b0;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.i_rx = d[i];
            step(BIT);
        end
        bus.i_rx = stop_bit;
        step(stop_len);
        bus.i_rx = 1'b1;
        if (stop_len < BIT) step(BIT - stop_len);
    endtask

    // Compare process: every pulse must be expected, in time, of the right kind;
    // o_data must always equal the last good byte (zero after reset).
    always @(negedge clk) begin : cmp
        ev_t e;
        if (rst_low_at_edge) exp_data = 8'h00;
        check("done_and_err_together", 32'(bus.o_rx_done & bus.o_frame_err), 32'd0);
        if (bus.o_rx_done || bus.o_frame_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, bus.o_rx_done, bus.o_frame_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_is_frame_err", 32'(bus.o_frame_err), 32'(e.is_err));
                tests++;
                if (cyc < e.lo || cyc > e.hi) begin
                    fails++;
                    $display("FAIL pulse_timing: pulse at cycle %0d, required in [%0d,%0d]", cyc, e.lo, e.hi);
                end
                if (!e.is_err) exp_data = e.data;
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
            tests++;
            fails++;
            $display("FAIL missing_pulse: none by cycle %0d, required by %0d (err=%0d data=%0h)",
                     cyc, exp_q[0].hi, exp_q[0].is_err, exp_q[0].data);
            void'(exp_q.pop_front());
        end
        check("o_data_held", 32'(bus.o_data), 32'(exp_data));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bus.i_rx = 1'b1;
        rst_n    = 1'b0;
        step(4);
        check("reset_data", 32'(bus.o_data), 32'h00);
        check("reset_done", 32'(bus.o_rx_done), 32'd0);
        check("reset_ferr", 32'(bus.o_frame_err), 32'd0);
        rst_n = 1'b1;
        step(20);

        send_frame(8'hA5, 1'b1, BIT);
        step(100);
        check("lit_data_a5", 32'(bus.o_data), 32'hA5);

        send_frame(8'h03, 1'b1, BIT);
        send_frame(8'h05, 1'b1, BIT);
        send_frame(8'h20, 1'b1, BIT);
        step(100);
        check("lit_data_b2b_last", 32'(bus.o_data), 32'h20);

        // Start-bit glitch lasting three ticks must be rejected silently.
        bus.i_rx = 1'b0;
        step(3 * BD);
        bus.i_rx = 1'b1;
        step(200);
        check("lit_data_after_glitch", 32'(bus.o_data), 32'h20);
        send_frame(8'h7E, 1'b1, BIT);
        step(100);
        check("lit_data_7e", 32'(bus.o_data), 32'h7E);

        // Stop bit low only around its sampling point so the release is not a new frame.
        send_frame(8'h3C, 1'b0, 40);
        step(150);
        check("lit_data_kept_on_ferr", 32'(bus.o_data), 32'h7E);

        // Reset pulse in the middle of data bit 4 of 0xFF aborts the frame.
        bus.i_rx = 1'b0;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.i_rx = 1'b1;
            if (i == 4) begin
                step(BIT / 2);
                rst_n = 1'b0;
                step(2);
                rst_n = 1'b1;
                check("lit_data_after_midreset", 32'(bus.o_data), 32'h00);
                check("lit_done_after_midreset", 32'(bus.o_rx_done), 32'd0);
                check("lit_ferr_after_midreset", 32'(bus.o_frame_err), 32'd0);
                step(BIT / 2 - 2);
            end else begin
                step(BIT);
            end
        end
        step(BIT + 100);
        send_frame(8'h00, 1'b1, BIT);
        step(100);
        check("lit_data_00", 32'(bus.o_data), 32'h00);

        // Break: two frame errors back to back, then reset clears the third attempt.
        t0 = cyc;
        push_ev(1'b1, 8'h00, t0 + 9 * BIT, t0 + 10 * BIT);
        push_ev(1'b1, 8'h00, t0 + 1180, t0 + 1280);
        bus.i_rx = 1'b0;
        step(1300);
        rst_n = 1'b0;
        step(2);
        rst_n    = 1'b1;
        bus.i_rx = 1'b1;
        step(100);
        check("lit_data_after_break", 32'(bus.o_data), 32'h00);

        step(10);
        check("all_expected_pulses_seen", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
